// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor.
// Holds the direction-counter constants, PC index/tag extraction helpers,
// and the update record the core carries down ID/EX with each instruction.
package bp_pkg;

   localparam int BP_XLEN = 32;

   // Saturated-taken value, all ones.
   function automatic int unsigned ctr_max(input int w);
      return (32'd1 << w) - 32'd1;
   endfunction

   // Weakly taken: MSB set, remaining bits clear.
   function automatic int unsigned ctr_weak_taken(input int w);
      return 32'd1 << (w - 1);
   endfunction

   // Weakly not-taken: MSB clear, remaining bits set.
   function automatic int unsigned ctr_weak_not_taken(input int w);
      return (32'd1 << (w - 1)) - 32'd1;
   endfunction

   // Table index: word-aligned PC bits directly above the byte offset.
   function automatic logic [BP_XLEN-1:0] pc_idx(input logic [BP_XLEN-1:0] pc,
                                                 input int idx_w);
      return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
   endfunction

   // Tag: the TAG_W bits immediately above the index field.
   function automatic logic [BP_XLEN-1:0] pc_tag(input logic [BP_XLEN-1:0] pc,
                                                 input int idx_w,
                                                 input int tag_w);
      return (pc >> (idx_w + 2)) & ((32'd1 << tag_w) - 32'd1);
   endfunction

   // Resolved-branch record as it leaves EX.
   typedef struct packed {
      logic               valid;
      logic [BP_XLEN-1:0] pc;
      logic               is_jump;
      logic               taken;
      logic [BP_XLEN-1:0] target;
      logic               pred_taken;
      logic [BP_XLEN-1:0] pred_target;
   } bp_upd_t;

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational saturating next-value for a W-bit direction counter.
// Ports:
//   cur     - current counter value
//   inc     - step up by one, holding at all-ones
//   dec     - step down by one, holding at zero
//   set_max - force all-ones (highest priority)
//   nxt     - resulting value
module bp_sat_counter #(
   parameter int W = 2
) (
   input  logic [W-1:0] cur,
   input  logic         inc,
   input  logic         dec,
   input  logic         set_max,
   output logic [W-1:0] nxt
);

   localparam logic [W-1:0] MAX = '1;

   always_comb begin
      nxt = cur;
      if (set_max) begin
         nxt = MAX;
      end else if (inc) begin
         if (cur != MAX) nxt = cur + W'(1);
      end else if (dec) begin
         if (cur != '0) nxt = cur - W'(1);
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters.
// IF looks up every cycle (combinational, no bypass of same-cycle updates);
// EX reports each resolved branch/jump, which trains the table and produces
// the redirect decision and corrected fetch PC.
// Ports:
//   clk, rst            - clock, synchronous active-low reset
//   lookup_pc           - IF-stage PC
//   pred_hit/taken/target - prediction for lookup_pc
//   upd_*               - resolved instruction from EX
//   flush_all           - invalidate every entry (fence.i)
//   redirect/redirect_pc - misprediction flush and corrected PC
//   cnt_resolved/cnt_mispred - wrapping performance counters
module branch_predictor
   import bp_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 16,
   parameter int TAG_W   = 8,
   parameter int CTR_W   = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] lookup_pc,
   output logic            pred_hit,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_is_jump,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target,
   input  logic            upd_pred_taken,
   input  logic [XLEN-1:0] upd_pred_target,
   input  logic            flush_all,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] cnt_resolved,
   output logic [XLEN-1:0] cnt_mispred
);

   localparam int IDX_W = $clog2(ENTRIES);

   localparam int unsigned CTR_MAX_I = ctr_max(CTR_W);
   localparam int unsigned CTR_WT_I  = ctr_weak_taken(CTR_W);
   localparam int unsigned CTR_WNT_I = ctr_weak_not_taken(CTR_W);
   localparam logic [CTR_W-1:0] CTR_MAX = CTR_MAX_I[CTR_W-1:0];
   localparam logic [CTR_W-1:0] CTR_WT  = CTR_WT_I[CTR_W-1:0];
   localparam logic [CTR_W-1:0] CTR_WNT = CTR_WNT_I[CTR_W-1:0];

   logic             valid_q   [ENTRIES];
   logic [TAG_W-1:0] tag_q     [ENTRIES];
   logic [CTR_W-1:0] ctr_q     [ENTRIES];
   logic [XLEN-1:0]  target_q  [ENTRIES];
   logic             is_jump_q [ENTRIES];

   // ---------------- lookup ----------------
   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic [XLEN-1:0]  lk_seq;

   assign lk_idx = lookup_pc[IDX_W+1:2];
   assign lk_tag = lookup_pc[IDX_W+2 +: TAG_W];
   assign lk_seq = lookup_pc + XLEN'(4);

   always_comb begin
      pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      pred_taken  = pred_hit && (is_jump_q[lk_idx] || ctr_q[lk_idx][CTR_W-1]);
      pred_target = pred_taken ? target_q[lk_idx] : lk_seq;
   end

   // ---------------- redirect ----------------
   // Compare against the carried-down predicted next PC rather than the
   // direction bit alone, so a taken branch with a stale target also flushes.
   logic [XLEN-1:0] actual_next;

   assign actual_next = upd_taken ? upd_target : (upd_pc + XLEN'(4));
   assign redirect    = upd_valid && (actual_next != upd_pred_target);
   assign redirect_pc = actual_next;

   // The direction bit travels with the record for the core's benefit; the
   // flush decision needs only the target.
   logic unused_pred_taken;
   assign unused_pred_taken = upd_pred_taken;

   // ---------------- training ----------------
   logic [IDX_W-1:0] up_idx;
   logic [TAG_W-1:0] up_tag;
   logic             up_hit;
   logic [CTR_W-1:0] ctr_nxt;

   assign up_idx = upd_pc[IDX_W+1:2];
   assign up_tag = upd_pc[IDX_W+2 +: TAG_W];
   assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

   bp_sat_counter #(
      .W (CTR_W)
   ) u_ctr (
      .cur     (ctr_q[up_idx]),
      .inc     (up_hit && !upd_is_jump && upd_taken),
      .dec     (up_hit && !upd_is_jump && !upd_taken),
      .set_max (up_hit && upd_is_jump),
      .nxt     (ctr_nxt)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]   <= 1'b0;
            tag_q[i]     <= '0;
            ctr_q[i]     <= CTR_WNT;
            target_q[i]  <= '0;
            is_jump_q[i] <= 1'b0;
         end
         cnt_resolved <= '0;
         cnt_mispred  <= '0;
      end else begin
         // Perf counters keep counting through a flush.
         if (upd_valid) cnt_resolved <= cnt_resolved + XLEN'(1);
         if (redirect)  cnt_mispred  <= cnt_mispred + XLEN'(1);

         if (flush_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
               valid_q[i] <= 1'b0;
            end
         end else if (upd_valid) begin
            if (up_hit) begin
               ctr_q[up_idx]     <= ctr_nxt;
               is_jump_q[up_idx] <= upd_is_jump;
               if (upd_taken) target_q[up_idx] <= upd_target;
            end else if (upd_taken) begin
               // Not-taken misses are not allocated: they would only
               // predict the fall-through that fetch produces anyway.
               valid_q[up_idx]   <= 1'b1;
               tag_q[up_idx]     <= up_tag;
               target_q[up_idx]  <= upd_target;
               is_jump_q[up_idx] <= upd_is_jump;
               ctr_q[up_idx]     <= upd_is_jump ? CTR_MAX : CTR_WT;
            end
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] lookup_pc;
   logic        pred_hit, pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid, upd_is_jump, upd_taken, upd_pred_taken;
   logic [31:0] upd_pc, upd_target, upd_pred_target;
   logic        flush_all;
   logic        redirect;
   logic [31:0] redirect_pc, cnt_resolved, cnt_mispred;

   always #5 clk = ~clk;

   branch_predictor #(
      .XLEN (32), .ENTRIES (16), .TAG_W (8), .CTR_W (2)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .lookup_pc       (lookup_pc),
      .pred_hit        (pred_hit),
      .pred_taken      (pred_taken),
      .pred_target     (pred_target),
      .upd_valid       (upd_valid),
      .upd_pc          (upd_pc),
      .upd_is_jump     (upd_is_jump),
      .upd_taken       (upd_taken),
      .upd_target      (upd_target),
      .upd_pred_taken  (upd_pred_taken),
      .upd_pred_target (upd_pred_target),
      .flush_all       (flush_all),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .cnt_resolved    (cnt_resolved),
      .cnt_mispred     (cnt_mispred)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Each entry is a record of plain integers; the direction counter is an
   // int in 0..3 with "taken" meaning value >= 2.
   bit          m_valid [16];
   int          m_tag   [16];
   int          m_ctr   [16];
   bit          m_jump  [16];
   logic [31:0] m_tgt   [16];
   logic [31:0] m_res, m_mis;

   function automatic int m_index(input logic [31:0] pc);
      return int'((pc / 4) % 16);
   endfunction

   function automatic int m_tagof(input logic [31:0] pc);
      return int'((pc / 64) % 256);
   endfunction

   task automatic m_lookup(input logic [31:0] pc, output bit h, output bit t,
                           output logic [31:0] tg);
      int i;
      i  = m_index(pc);
      h  = m_valid[i] && (m_tag[i] == m_tagof(pc));
      t  = h && (m_jump[i] || m_ctr[i] >= 2);
      tg = t ? m_tgt[i] : pc + 32'd4;
   endtask

   function automatic logic [31:0] m_actual();
      return upd_taken ? upd_target : upd_pc + 32'd4;
   endfunction

   task automatic drive(input bit r, input logic [31:0] lpc, input bit uv,
                        input logic [31:0] upc, input bit uj, input bit ut,
                        input logic [31:0] utgt, input logic [31:0] uptgt,
                        input bit fl);
      rst             = r;
      lookup_pc       = lpc;
      upd_valid       = uv;
      upd_pc          = upc;
      upd_is_jump     = uj;
      upd_taken       = ut;
      upd_target      = utgt;
      upd_pred_target = uptgt;
      upd_pred_taken  = (uptgt != upc + 32'd4);
      flush_all       = fl;
      #2;
   endtask

   task automatic model_check();
      bit h, t, red;
      logic [31:0] tg;
      m_lookup(lookup_pc, h, t, tg);
      chk("m_hit", {31'd0, pred_hit}, {31'd0, h});
      chk("m_taken", {31'd0, pred_taken}, {31'd0, t});
      chk("m_target", pred_target, tg);
      red = upd_valid && (m_actual() != upd_pred_target);
      chk("m_redirect", {31'd0, redirect}, {31'd0, red});
      if (upd_valid) chk("m_redirect_pc", redirect_pc, m_actual());
      chk("m_cnt_resolved", cnt_resolved, m_res);
      chk("m_cnt_mispred", cnt_mispred, m_mis);
   endtask

   task automatic tick();
      bit h, t, red;
      logic [31:0] tg;
      int i;
      @(posedge clk);
      if (!rst) begin
         for (int k = 0; k < 16; k++) begin
            m_valid[k] = 0; m_tag[k] = 0; m_ctr[k] = 1; m_jump[k] = 0; m_tgt[k] = 0;
         end
         m_res = 0;
         m_mis = 0;
      end else begin
         m_lookup(upd_pc, h, t, tg);
         red = upd_valid && (m_actual() != upd_pred_target);
         if (upd_valid) m_res = m_res + 1;
         if (red)       m_mis = m_mis + 1;
         i = m_index(upd_pc);
         if (flush_all) begin
            for (int k = 0; k < 16; k++) m_valid[k] = 0;
         end else if (upd_valid && h) begin
            if (upd_is_jump)    m_ctr[i] = 3;
            else if (upd_taken) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            else                m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            m_jump[i] = upd_is_jump;
            if (upd_taken) m_tgt[i] = upd_target;
         end else if (upd_valid && upd_taken) begin
            m_valid[i] = 1;
            m_tag[i]   = m_tagof(upd_pc);
            m_tgt[i]   = upd_target;
            m_jump[i]  = upd_is_jump;
            m_ctr[i]   = upd_is_jump ? 3 : 2;
         end
      end
      @(negedge clk);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [31:0] lpc;
      bit          uv;
      logic [31:0] upc;
      bit          uj;
      bit          ut;
      logic [31:0] utgt;
      logic [31:0] uptgt;
      bit          e_hit;
      bit          e_taken;
      logic [31:0] e_tgt;
      bit          e_red;
      logic [31:0] e_rpc;
      logic [31:0] e_res;
      logic [31:0] e_mis;
   } vec_t;

   vec_t tbl [14];

   initial begin
      //         lpc     uv upc    uj ut utgt    uptgt   hit tk tgt     red rpc     res mis
      tbl[0]  = '{32'h40,  0, 32'h0,  0, 0, 32'h0,   32'h0,   0, 0, 32'h44,  0, 32'h0,   0, 0};
      tbl[1]  = '{32'h40,  1, 32'h40, 0, 1, 32'h100, 32'h44,  0, 0, 32'h44,  1, 32'h100, 0, 0};
      tbl[2]  = '{32'h40,  0, 32'h0,  0, 0, 32'h0,   32'h0,   1, 1, 32'h100, 0, 32'h0,   1, 1};
      tbl[3]  = '{32'h40,  1, 32'h40, 0, 0, 32'h100, 32'h100, 1, 1, 32'h100, 1, 32'h44,  1, 1};
      tbl[4]  = '{32'h40,  1, 32'h40, 0, 0, 32'h100, 32'h44,  1, 0, 32'h44,  0, 32'h44,  2, 2};
      tbl[5]  = '{32'h440, 0, 32'h0,  0, 0, 32'h0,   32'h0,   0, 0, 32'h444, 0, 32'h0,   3, 2};
      tbl[6]  = '{32'h40,  1, 32'h440,0, 1, 32'h300, 32'h444, 1, 0, 32'h44,  1, 32'h300, 3, 2};
      tbl[7]  = '{32'h40,  0, 32'h0,  0, 0, 32'h0,   32'h0,   0, 0, 32'h44,  0, 32'h0,   4, 3};
      tbl[8]  = '{32'h440, 0, 32'h0,  0, 0, 32'h0,   32'h0,   1, 1, 32'h300, 0, 32'h0,   4, 3};
      tbl[9]  = '{32'h80,  1, 32'h80, 1, 1, 32'h200, 32'h84,  0, 0, 32'h84,  1, 32'h200, 4, 3};
      tbl[10] = '{32'h80,  1, 32'h80, 1, 1, 32'h200, 32'h200, 1, 1, 32'h200, 0, 32'h200, 5, 4};
      tbl[11] = '{32'h80,  1, 32'h80, 1, 1, 32'h200, 32'h200, 1, 1, 32'h200, 0, 32'h200, 6, 4};
      tbl[12] = '{32'h80,  1, 32'h80, 0, 0, 32'h200, 32'h200, 1, 1, 32'h200, 1, 32'h84,  7, 4};
      tbl[13] = '{32'h80,  0, 32'h0,  0, 0, 32'h0,   32'h0,   1, 1, 32'h200, 0, 32'h0,   8, 5};
   end

   initial begin
      logic [31:0] lpc, upc, utgt, uptgt, mt;
      bit uj, ut, uv, fl, r, mh, mtk;

      @(negedge clk);
      drive(0, 32'h40, 1, 32'h40, 0, 1, 32'h100, 32'h44, 1);
      tick();
      tick();

      for (int i = 0; i < 14; i++) begin
         drive(1, tbl[i].lpc, tbl[i].uv, tbl[i].upc, tbl[i].uj, tbl[i].ut,
               tbl[i].utgt, tbl[i].uptgt, 0);
         chk($sformatf("v%0d_hit", i), {31'd0, pred_hit}, {31'd0, tbl[i].e_hit});
         chk($sformatf("v%0d_taken", i), {31'd0, pred_taken}, {31'd0, tbl[i].e_taken});
         chk($sformatf("v%0d_target", i), pred_target, tbl[i].e_tgt);
         chk($sformatf("v%0d_redirect", i), {31'd0, redirect}, {31'd0, tbl[i].e_red});
         if (tbl[i].uv) chk($sformatf("v%0d_redirect_pc", i), redirect_pc, tbl[i].e_rpc);
         chk($sformatf("v%0d_cnt_resolved", i), cnt_resolved, tbl[i].e_res);
         chk($sformatf("v%0d_cnt_mispred", i), cnt_mispred, tbl[i].e_mis);
         model_check();
         tick();
      end

      // flush_all together with an allocating update: table empties, counters still count
      drive(1, 32'h80, 1, 32'h44, 0, 1, 32'h500, 32'h48, 1);
      model_check();
      tick();
      drive(1, 32'h80, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
      chk("flush_hit_80", {31'd0, pred_hit}, 32'd0);
      chk("flush_cnt_resolved", cnt_resolved, 32'd9);
      chk("flush_cnt_mispred", cnt_mispred, 32'd6);
      lookup_pc = 32'h44;
      #1;
      chk("flush_drop_update_44", {31'd0, pred_hit}, 32'd0);
      model_check();
      tick();

      // allocate a jump, then reset while an update is presented
      drive(1, 32'h40, 1, 32'h40, 1, 1, 32'h600, 32'h44, 0);
      model_check();
      tick();
      drive(1, 32'h40, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
      chk("jump_alloc_hit", {31'd0, pred_hit}, 32'd1);
      chk("jump_alloc_target", pred_target, 32'h600);
      drive(0, 32'h40, 1, 32'h84, 0, 1, 32'h700, 32'h88, 0);
      tick();
      drive(1, 32'h84, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
      chk("rst_no_write_hit", {31'd0, pred_hit}, 32'd0);
      chk("rst_target", pred_target, 32'h88);
      chk("rst_cnt_resolved", cnt_resolved, 32'd0);
      chk("rst_cnt_mispred", cnt_mispred, 32'd0);
      lookup_pc = 32'h40;
      #1;
      chk("rst_invalidates_40", {31'd0, pred_hit}, 32'd0);
      tick();

      // randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         lpc  = ($urandom_range(0, 9) == 0) ? $urandom()
              : ((32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 3)) << 2));
         upc  = ($urandom_range(0, 9) == 0) ? ($urandom() & ~32'h3)
              : ((32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 3)) << 2));
         uv   = ($urandom_range(0, 3) != 0);
         uj   = ($urandom_range(0, 3) == 0);
         ut   = uj ? 1'b1 : 1'($urandom_range(0, 1));
         utgt = 32'h1000 + (32'($urandom_range(0, 1)) << 4);
         m_lookup(upc, mh, mtk, mt);
         uptgt = ($urandom_range(0, 9) < 7) ? mt : (32'h1000 + (32'($urandom_range(0, 3)) << 2));
         fl   = ($urandom_range(0, 39) == 0);
         r    = ($urandom_range(0, 99) != 0);
         drive(r, lpc, uv, upc, uj, ut, utgt, uptgt, fl);
         model_check();
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
